kogge_stone_adder16: RTL and testbench

Registered 16-bit Kogge-Stone parallel-prefix adder with carry-in and carry-out, used as the fast add primitive in the datapath. It computes `sum = a + b + c_in` through a 4-level logarithmic prefix network and registers the result on the rising clock edge. A valid flag travels with the data so downstream logic knows when the result is meaningful.

---
 rtl/kogge_stone_adder16.sv | 131 +++++++++++++
 tb/tb_kogge_stone_adder16.sv | 109 ++++++++++
 2 files changed

// File: rtl/kogge_stone_adder16.sv
// kogge_stone_adder16: registered 16-bit Kogge-Stone adder, sum = a + b + c_in.
// Four prefix levels (span 1, 2, 4, 8) with c_in folded into bit 0 generate.
// Optional build macro KSA_PIPE_EN: adds a register stage after prefix level 2
// (latency 2 instead of 1); results are identical in both builds.
module kogge_stone_adder16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out,
  output logic        out_valid
);

  localparam int unsigned W = 16;

  // Bit-level generate/propagate; p vectors are kept only where a later level reads them.
  logic [W-1:0] g0, p0;
  logic [W-1:0] g1, g2, g3, g4;
  logic [W-1:2] p1;
  logic [W-1:4] p2;
  logic [W-1:8] p3;

  // Values crossing the optional pipeline boundary after level 2.
  logic [W-1:0] gs;
  logic [W-1:4] ps;
  logic [W-1:0] p_s;
  logic         cin_s;
  logic         vld_s;

  logic [W-1:0] sum_d, sum_q;
  logic         c_out_d, c_out_q;
  logic         out_valid_q;

  assign p0 = a ^ b;
  assign g0 = (a & b) | {{(W-1){1'b0}}, p0[0] & c_in};

  // Prefix levels 1 and 2 (span 1 and 2).
  for (genvar i = 0; i < W; i++) begin : g_lvl12
    if (i >= 1) begin : g_l1_comb
      assign g1[i] = g0[i] | (p0[i] & g0[i-1]);
    end else begin : g_l1_pass
      assign g1[i] = g0[i];
    end
    if (i >= 2) begin : g_l1_p
      assign p1[i] = p0[i] & p0[i-1];
      assign g2[i] = g1[i] | (p1[i] & g1[i-2]);
    end else begin : g_l2_pass
      assign g2[i] = g1[i];
    end
    if (i >= 4) begin : g_l2_p
      assign p2[i] = p1[i] & p1[i-2];
    end
  end

`ifdef KSA_PIPE_EN
  logic [W-1:0] g2_q;
  logic [W-1:4] p2_q;
  logic [W-1:0] p_q;
  logic         cin_q;
  logic         vld_q;

  // Mid-network register stage holding level-2 (G,P), raw p, c_in and valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g2_q  <= '0;
      p2_q  <= '0;
      p_q   <= '0;
      cin_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      g2_q  <= g2;
      p2_q  <= p2;
      p_q   <= p0;
      cin_q <= c_in;
      vld_q <= in_valid;
    end
  end

  assign gs    = g2_q;
  assign ps    = p2_q;
  assign p_s   = p_q;
  assign cin_s = cin_q;
  assign vld_s = vld_q;
`else
  assign gs    = g2;
  assign ps    = p2;
  assign p_s   = p0;
  assign cin_s = c_in;
  assign vld_s = in_valid;
`endif

  // Prefix levels 3 and 4 (span 4 and 8); level 4 needs only G.
  for (genvar i = 0; i < W; i++) begin : g_lvl34
    if (i >= 4) begin : g_l3_comb
      assign g3[i] = gs[i] | (ps[i] & gs[i-4]);
    end else begin : g_l3_pass
      assign g3[i] = gs[i];
    end
    if (i >= 8) begin : g_l4_comb
      assign p3[i] = ps[i] & ps[i-4];
      assign g4[i] = g3[i] | (p3[i] & g3[i-8]);
    end else begin : g_l4_pass
      assign g4[i] = g3[i];
    end
  end

  // Sum bit i uses the carry out of bit i-1; bit 0 uses c_in directly.
  assign sum_d   = p_s ^ {g4[W-2:0], cin_s};
  assign c_out_d = g4[W-1];

  // Output register; loads every cycle, valid travels alongside.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      c_out_q     <= c_out_d;
      out_valid_q <= vld_s;
    end
  end

  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_kogge_stone_adder16.sv
// tb_kogge_stone_adder16: directed vectors, random stream and async reset pulse
// for kogge_stone_adder16; latency follows the KSA_PIPE_EN build macro.
module tb_kogge_stone_adder16;

`ifdef KSA_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int N = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] a, b;
  logic        c_in;
  logic [15:0] sum;
  logic        c_out;
  logic        out_valid;

  int errors = 0;
  int checks = 0;

  logic [17:0] exp_q [0:N-1];

  kogge_stone_adder16 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c_in(c_in),
    .sum(sum), .c_out(c_out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one operand set, wait the configured latency, check the result.
  task automatic run_vec(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic vc, input logic [15:0] es, input logic eco);
    @(negedge clk);
    a = va; b = vb; c_in = vc; in_valid = 1'b1;
    repeat (LAT) @(posedge clk);
    #1;
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(c_out), 32'(eco));
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sum", 32'(sum), 32'h0);
    chk("rst_cout", 32'(c_out), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    run_vec("zero", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
    run_vec("a701", 16'hA701, 16'h9500, 1'b0, 16'h3C01, 1'b1);
    run_vec("ffff_cin", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
    run_vec("7fff", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
    run_vec("max", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    run_vec("alt", 16'h5555, 16'hAAAA, 1'b0, 16'hFFFF, 1'b0);

    // Back-to-back random stream; output at negedge t reflects inputs driven at t-LAT.
    for (int t = 0; t < N + LAT; t++) begin
      @(negedge clk);
      if (t >= LAT) begin
        chk("strm_valid", 32'(out_valid), 32'(exp_q[t-LAT][17]));
        chk("strm_sum", 32'({c_out, sum}), 32'(exp_q[t-LAT][16:0]));
      end
      if (t < N) begin
        a = 16'($urandom); b = 16'($urandom);
        c_in = 1'($urandom); in_valid = 1'($urandom);
        exp_q[t] = {in_valid, 17'(a) + 17'(b) + 17'(c_in)};
      end
    end

    // Two valid ops in flight, then a half-cycle reset pulse between edges.
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; c_in = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 16'h8000; b = 16'h8000; c_in = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    a = '0; b = '0; c_in = 1'b0; in_valid = 1'b0;
    chk("pre_pulse_valid", 32'(out_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("pulse_sum", 32'(sum), 32'h0);
    chk("pulse_cout", 32'(c_out), 32'h0);
    chk("pulse_valid", 32'(out_valid), 32'h0);
    #4 rst = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      chk("post_pulse_valid", 32'(out_valid), 32'h0);
      chk("post_pulse_sum", 32'({c_out, sum}), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
